// File: rtl/dbg_pkg.sv
// Shared debug-link definitions: command encodings, response bytes and the
// host bridge state type. Also used by dbg_module.
package dbg_pkg;

  localparam logic [7:0] DBG_CMD_NOP      = 8'h00;
  localparam logic [7:0] DBG_CMD_READ     = 8'h01;
  localparam logic [7:0] DBG_CMD_WRITE    = 8'h02;
  localparam logic [7:0] DBG_CMD_HALT     = 8'h03;
  localparam logic [7:0] DBG_CMD_RESUME   = 8'h04;
  localparam logic [7:0] DBG_CMD_STEP     = 8'h05;
  localparam logic [7:0] DBG_CMD_RST_CORE = 8'h06;
  localparam logic [7:0] DBG_CMD_RST_ALL  = 8'h07;

  localparam logic [7:0] DBG_RESP_ERR     = 8'hEE;
  localparam logic [7:0] DBG_RESP_BAD_CMD = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_ISSUE,
    ST_WAIT,
    ST_TX_RESP
  } dbg_bridge_state_t;

  // Commands that carry no address/data payload.
  function automatic logic is_single_byte_cmd(input logic [7:0] cmd);
    return (cmd >= DBG_CMD_HALT) && (cmd <= DBG_CMD_RST_ALL);
  endfunction

endpackage

// File: rtl/dbg_resp_ser.sv
// Response serializer: loads a 1- or 4-byte response and emits it MSB first
// over a valid/ready byte stream.
module dbg_resp_ser (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        load,
  input  logic        load_len4,
  input  logic [31:0] load_word,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [31:0] shift_q;
  logic [2:0]  left_q;

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      shift_q <= '0;
      left_q  <= '0;
    end else if (load) begin
      shift_q <= load_len4 ? load_word : {load_word[7:0], 24'h000000};
      left_q  <= load_len4 ? 3'd4 : 3'd1;
    end else if (tx_valid_o && tx_ready_i) begin
      shift_q <= {shift_q[23:0], 8'h00};
      left_q  <= left_q - 3'd1;
    end
  end

  assign tx_valid_o = (left_q != 3'd0);
  assign tx_data_o  = shift_q[31:24];
  assign done_o     = tx_valid_o && tx_ready_i && (left_q == 3'd1);

endmodule

// File: rtl/dbg_host_bridge.sv
// Host byte-stream to debug-module command bridge.
// Optional WAIT timeout with error response: define DBG_BRIDGE_TIMEOUT_EN.
module dbg_host_bridge
  import dbg_pkg::*;
#(
`ifdef DBG_BRIDGE_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ERR_BYTE       = DBG_RESP_ERR,
`endif
  parameter logic [7:0]  BAD_CMD_BYTE   = DBG_RESP_BAD_CMD
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i
);

  dbg_bridge_state_t state_q, state_d;
  logic [7:0]  cmd_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  cnt_q;
  logic        rx_fire;
  logic        ser_load;
  logic        ser_len4;
  logic [31:0] ser_word;
  logic        ser_done;

  assign rx_ready_o = !rst_i && (state_q inside {ST_IDLE, ST_RX_ADDR, ST_RX_DATA});
  assign rx_fire    = rx_valid_i && rx_ready_o;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cmd_q   <= DBG_CMD_NOP;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (rx_fire) begin
        case (state_q)
          ST_IDLE: begin
            cmd_q <= rx_data_i;
            cnt_q <= '0;
          end
          ST_RX_ADDR: begin
            addr_q <= {addr_q[23:0], rx_data_i};
            cnt_q  <= cnt_q + 2'd1;
          end
          ST_RX_DATA: begin
            data_q <= {data_q[23:0], rx_data_i};
            cnt_q  <= cnt_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DBG_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q;

  // Held at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (rst_i || (state_q != ST_WAIT)) to_cnt_q <= '0;
    else                               to_cnt_q <= to_cnt_q + 1'b1;
  end
`endif

  // NOTE: every signal gets a default first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    ser_load = 1'b0;
    ser_len4 = 1'b0;
    ser_word = '0;
    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (rx_data_i == DBG_CMD_NOP) begin
            state_d = ST_IDLE;
          end else if ((rx_data_i == DBG_CMD_READ) || (rx_data_i == DBG_CMD_WRITE)) begin
            state_d = ST_RX_ADDR;
          end else if (is_single_byte_cmd(rx_data_i)) begin
            state_d = ST_ISSUE;
          end else begin
            ser_load = 1'b1;
            ser_word = {24'h000000, BAD_CMD_BYTE};
            state_d  = ST_TX_RESP;
          end
        end
      end
      ST_RX_ADDR: begin
        if (rx_fire && (cnt_q == 2'd3))
          state_d = (cmd_q == DBG_CMD_WRITE) ? ST_RX_DATA : ST_ISSUE;
      end
      ST_RX_DATA: begin
        if (rx_fire && (cnt_q == 2'd3)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (dbg_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dbg_ready_i) begin
          ser_load = 1'b1;
          if (cmd_q == DBG_CMD_READ) begin
            ser_len4 = 1'b1;
            ser_word = dbg_data_i;
          end else begin
            ser_word = {24'h000000, cmd_q};
          end
          state_d = ST_TX_RESP;
        end
`ifdef DBG_BRIDGE_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          ser_load = 1'b1;
          ser_word = {24'h000000, ERR_BYTE};
          state_d  = ST_TX_RESP;
        end
`endif
      end
      ST_TX_RESP: begin
        if (ser_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The command is visible only while issuing/waiting, so it is never replayed.
  assign dbg_cmd_o  = (state_q inside {ST_ISSUE, ST_WAIT}) ? cmd_q : DBG_CMD_NOP;
  assign dbg_addr_o = addr_q;
  assign dbg_data_o = data_q;

  dbg_resp_ser u_resp_ser (
    .clk        (clk),
    .rst_i      (rst_i),
    .load       (ser_load),
    .load_len4  (ser_len4),
    .load_word  (ser_word),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .done_o     (ser_done)
  );

endmodule

// File: doc/dbg_host_bridge.md
Name: dbg_host_bridge

Overview:
Host-side initiator for the debug module's command/ready interface. It receives framed command bytes from a byte stream (e.g. UART RX), assembles the command, address and data words, and drives them to the debug module. It waits for completion, then returns a response over a byte stream (e.g. UART TX). It sits between the host link and the debug module, so the test host can halt, reset, read and write the SoC.

Parameters:
TIMEOUT_CYCLES, 1024, WAIT-state cycle limit before an error response (used only with the optional feature).
ERR_BYTE, 8'hEE, response byte sent on timeout.
BAD_CMD_BYTE, 8'hFF, response byte sent for an unsupported command.

Ports:
clk  in  1  system clock.
rst_i  in  1  synchronous reset, active-high.
rx_data_i  in  8  incoming host byte.
rx_valid_i  in  1  rx_data_i valid.
rx_ready_o  out  1  bridge accepts rx byte; a transfer occurs when rx_valid_i && rx_ready_o.
tx_data_o  out  8  response byte.
tx_valid_o  out  1  tx_data_o valid; held until accepted.
tx_ready_i  in  1  sink accepts tx byte.
dbg_cmd_o  out  8  command to the debug module (8'h00 = nop).
dbg_addr_o  out  32  address to the debug module.
dbg_data_o  out  32  write data to the debug module.
dbg_data_i  in  32  read data from the debug module.
dbg_ready_i  in  1  debug module ready/done.

Behaviour:
- Single clock domain (clk). rst_i is synchronous, active-high.
- Reset values:
  - State is IDLE.
  - rx_ready_o=0 while rst_i is high, then 1 from the first cycle after release.
  - tx_valid_o=0, tx_data_o=0, dbg_cmd_o=8'h00, dbg_addr_o=0, dbg_data_o=0.
  - Byte counter=0.
- Frame format (multi-byte words are sent MSB first):
  - 8'h01: 4 address bytes.
  - 8'h02: 4 address bytes, then 4 data bytes.
  - 8'h03..8'h07: command byte only.
- States:
  - IDLE, rx_ready_o=1. On accepting a byte:
    - 8'h00: dropped, no response.
    - 8'h01 or 8'h02: latch cmd, go to RX_ADDR.
    - 8'h03..8'h07: go to ISSUE.
    - >8'h07: go to TX_RESP with BAD_CMD_BYTE; nothing is forwarded.
  - RX_ADDR, rx_ready_o=1. Shift a byte into the address register per accept; 2-bit counter. After the 4th byte, cmd 01 goes to ISSUE and cmd 02 goes to RX_DATA.
  - RX_DATA: same as RX_ADDR into the data register; after the 4th byte, go to ISSUE.
  - ISSUE, rx_ready_o=0. Stall until dbg_ready_i=1. In that cycle drive dbg_cmd_o=cmd, addr and data stable, then go to WAIT. Exactly one ISSUE cycle is spent with the command driven while ready is high.
  - WAIT: keep dbg_cmd_o, addr and data stable. On the first cycle with dbg_ready_i=1:
    - dbg_cmd_o becomes 8'h00 the next cycle.
    - cmd 01 captures dbg_data_i into the response register (4 bytes).
    - Other commands load the ack byte, equal to the cmd byte (1 byte).
    - Go to TX_RESP.
    - Ready=1 in the first WAIT cycle completes the command; this is correct for single-cycle commands 03..07.
  - TX_RESP: tx_valid_o=1 with the current byte. Advance on tx_ready_i; after the last byte, go to IDLE. Read data is sent MSB first.
- dbg_cmd_o is 8'h00 in every state except ISSUE and WAIT, so the debug module never re-executes a command.
- rx_ready_o=0 in ISSUE, WAIT and TX_RESP. Host bytes sent then are back-pressured, never lost.
- Latency for cmd 03 with the target ready: last rx byte accepted in cycle T, ISSUE at T+1, WAIT at T+2, tx_valid_o=1 at T+3.
- Reset mid-operation: the partial frame is discarded, dbg_cmd_o returns to 00 and any pending response is dropped.

Optional Feature:
DBG_BRIDGE_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with dbg_ready_i still 0, dbg_cmd_o goes to 00 and the bridge sends the single byte ERR_BYTE, then returns to IDLE.
- Not defined: WAIT has no limit and no counter logic is present.

Decomposition:
- Package dbg_pkg:
  - Command constants DBG_CMD_NOP..DBG_CMD_RST_ALL (8'h00..8'h07).
  - State enum dbg_bridge_state_t.
  - Response constants.
  - dbg_module also uses this package.
- Sub-module dbg_resp_ser: loadable 4-byte MSB-first serializer with a byte count of 1 or 4 and a valid/ready output.

Test Plan:
1. Rx 03 -> dbg_cmd_o=03 for ISSUE plus one cycle (target ready), then 00; tx byte 03; halt asserted at target.
2. Rx 01 00 00 10 00, target returns 32'hDEADBEEF after 3 ready-low cycles -> dbg_addr_o=32'h00001000; tx DE AD BE EF in order.
3. Rx 02 00 00 00 04 CA FE BA BE -> dbg_addr_o=32'h4, dbg_data_o=32'hCAFEBABE stable through WAIT; tx byte 02.
4. Rx 00 then 09 -> 00: no tx, dbg_cmd_o stays 00; 09: tx FF and dbg_cmd_o never leaves 00.
5. tx_ready_i held low for 10 cycles during a read response -> tx_valid_o and tx_data_o stable; rx_ready_o=0; no byte lost.
6. rst_i pulsed after 2 address bytes -> all outputs at reset values; a subsequent full 05 frame completes normally. With DBG_BRIDGE_TIMEOUT_EN and dbg_ready_i stuck low -> tx EE after TIMEOUT_CYCLES.
